fp_to_fixed: RTL and testbench
==============================

// Module: fp_to_fixed
// PURPOSE
//  Pipelined IEEE-style float-to-fixed converter: decode side of the fp datapath (fp_add/fp_mul results -> fixed-point).
//  Converts one I_DATA-bit float per cycle to signed two's-complement Q(O_WIDTH-O_FRAC).O_FRAC.
//  Uses round-to-nearest-even and saturation. Feeds the fixed-point FFT/MIMO back end. Fixed 3-cycle latency, fully pipelined.
// PARAMETERS
//  I_EXP   8                    exponent width
//  I_MNT   23                   stored mantissa width (hidden 1 implicit)
//  I_DATA  I_EXP+I_MNT+1        float word width {sign, exp, mnt}
//  O_WIDTH 16                   fixed-point output width (signed)
//  O_FRAC  12                   fractional bits of output (O_FRAC < O_WIDTH)
// PORTS
//  clk        in   1        clock, all state on posedge
//  reset      in   1        synchronous, active-high
//  enable     in   1        input valid; idata sampled on posedge when high
//  idata      in   I_DATA   float operand
//  odata      out  O_WIDTH  fixed-point result
//  out_valid  out  1        odata valid this cycle
//  sat        out  1        result saturated (overflow/inf) or input NaN; qualified by out_valid
// BEHAVIOUR
//  Reset: odata=0, out_valid=0, sat=0, all stage valids cleared; applies mid-flight, in-flight items dropped.
//  Pipeline advances every cycle (no backpressure); valid bit travels with data: out_valid(t+3)=enable(t).
//  enable low = bubble: out_valid low 3 cycles later, odata/sat hold previous value.
//  S1 (unpack/classify): sign, E, sig={1,M} (I_MNT+1 bits); bias=2^(I_EXP-1)-1;
//     s = E - bias + O_FRAC - I_MNT (signed, width I_EXP+2); class = ZERO (E==0, incl. denormals, flushed),
//     SPECIAL (E all ones: inf if M==0, NaN else), NORMAL.
//  S2 (shift/round): s>=0: mag = sig<<s, overflow if any bit shifted past O_WIDTH (s >= O_WIDTH clamps to overflow);
//     s<0: mag = sig>>(-s); guard = last dropped bit, sticky = OR of rest; round up if guard & (sticky | mag[0]);
//     -s > I_MNT+1 -> mag=0 (guard/sticky computed correctly, never round up past 0.5 LSB).
//     Magnitude register width O_WIDTH+1 to hold -min case and carry from rounding.
//  S3 (sign/saturate): limit = sign ? 2^(O_WIDTH-1) : 2^(O_WIDTH-1)-1;
//     mag>limit or overflow or inf -> odata = sign ? min (100..0) : max (011..1), sat=1;
//     NaN -> odata=0, sat=1; ZERO -> odata=0 (also -0), sat=0; else odata = sign ? -mag : mag, sat=0.
//  Exactly -2^(O_WIDTH-1-O_FRAC) converts to min without sat.
//  No internal state beyond the 3 pipeline registers; back-to-back inputs every cycle accepted indefinitely.
// TESTING (I_EXP=8, I_MNT=23, O_WIDTH=16, O_FRAC=12)
//  1) reset high 2 cycles with enable=1 -> out_valid=0, odata=0 throughout; first out_valid 3 cycles after release.
//  2) stream 0x3FC00000, 0x3EEEFE8B, 0xC0000000 back-to-back -> 0x1800, 0x0778, 0xE000 on consecutive cycles, sat=0.
//  3) 0x41000000 (8.0) -> 0x7FFF sat=1; 0xC1000000 (-8.0) -> 0x8000 sat=0; 0x7F800000 -> 0x7FFF sat=1; 0xFF800000 -> 0x8000 sat=1.
//  4) RNE ties: 0x39000000 (0.5 LSB) -> 0x0000; 0x39C00000 (1.5 LSB) -> 0x0002; 0x3A200000 (2.5 LSB) -> 0x0002.
//  5) 0x7FC00000 (NaN) -> 0x0000 sat=1; 0x80000000 and 0x00000001 (denormal) -> 0x0000 sat=0; 0x00800000 -> 0x0000.
//  6) enable pattern 1,0,1,1 with reset pulsed in cycle 2 -> only post-reset items emerge, bubbles keep out_valid low.

Source files
------------

// File: rtl/fp_to_fixed.sv
// Float to signed fixed-point Q(O_WIDTH-O_FRAC).O_FRAC, round-to-nearest-even, saturating.
// Latency: 3 cycles, one result per cycle.
// Backpressure: none; the pipeline advances every cycle and bubbles hold odata/sat.
module fp_to_fixed #(
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter int I_DATA  = I_EXP + I_MNT + 1,
  parameter int O_WIDTH = 16,
  parameter int O_FRAC  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [I_DATA-1:0]   idata,
  output logic [O_WIDTH-1:0]  odata,
  output logic                out_valid,
  output logic                sat
);

  localparam int SW = I_EXP + 2;
  localparam int SG = I_MNT + 1;
  localparam int W  = O_WIDTH + SG + 1;

  localparam logic signed [SW-1:0] S_OFF  = SW'(O_FRAC - I_MNT - (2**(I_EXP-1) - 1));
  localparam logic signed [SW-1:0] OW_S   = SW'(O_WIDTH);
  localparam logic        [SW-1:0] RMAX_V = SW'(SG + 1);
  localparam logic [O_WIDTH:0]     LIM_POS = {2'b00, {(O_WIDTH-1){1'b1}}};
  localparam logic [O_WIDTH:0]     LIM_NEG = {2'b01, {(O_WIDTH-1){1'b0}}};
  localparam logic [O_WIDTH-1:0]   MAX_V   = {1'b0, {(O_WIDTH-1){1'b1}}};
  localparam logic [O_WIDTH-1:0]   MIN_V   = {1'b1, {(O_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_t;

  // stage 1: unpack / classify
  logic              sgn_in;
  logic [I_EXP-1:0]  e_in;
  logic [I_MNT-1:0]  m_in;
  cls_t              cls_n;

  assign sgn_in = idata[I_DATA-1];
  assign e_in   = idata[I_DATA-2 -: I_EXP];
  assign m_in   = idata[I_MNT-1:0];

  always_comb begin
    cls_n = CL_NORM;
    if (e_in == '0)
      cls_n = CL_ZERO;
    else if (&e_in)
      cls_n = (m_in == '0) ? CL_INF : CL_NAN;
  end

  logic                  v1, sgn1;
  cls_t                  cls1;
  logic [SG-1:0]         sig1;
  logic signed [SW-1:0]  sh1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      sgn1 <= 1'b0;
      cls1 <= CL_ZERO;
      sig1 <= '0;
      sh1  <= '0;
    end else begin
      v1 <= enable;
      if (enable) begin
        sgn1 <= sgn_in;
        cls1 <= cls_n;
        sig1 <= {1'b1, m_in};
        sh1  <= $signed({2'b00, e_in}) + S_OFF;
      end
    end
  end

  // stage 2: align and round; huge right shifts clamp to leave only sticky bits
  logic [W-1:0]     val;
  logic [2*SG-1:0]  ext;
  logic [SW-1:0]    rsh;
  logic             guard, sticky, ovf_n;

  always_comb begin
    val    = '0;
    ext    = '0;
    rsh    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    ovf_n  = 1'b0;
    if (!sh1[SW-1]) begin
      if (sh1 >= OW_S)
        ovf_n = 1'b1;
      else
        val = W'(sig1) << sh1;
    end else begin
      rsh = -sh1;
      if (rsh > RMAX_V)
        rsh = RMAX_V;
      ext    = {sig1, {SG{1'b0}}} >> rsh;
      guard  = ext[SG-1];
      sticky = |ext[SG-2:0];
      val    = W'(ext[2*SG-1:SG]) + W'(guard & (sticky | ext[SG]));
    end
    ovf_n = ovf_n | (|val[W-1:O_WIDTH+1]);
  end

  logic              v2, sgn2, ovf2;
  cls_t              cls2;
  logic [O_WIDTH:0]  mag2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2   <= 1'b0;
      sgn2 <= 1'b0;
      ovf2 <= 1'b0;
      cls2 <= CL_ZERO;
      mag2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sgn2 <= sgn1;
        ovf2 <= ovf_n;
        cls2 <= cls1;
        mag2 <= val[O_WIDTH:0];
      end
    end
  end

  // stage 3: sign apply / saturate; negative side allows one extra magnitude step
  logic [O_WIDTH-1:0] d_n;
  logic               s_n;

  always_comb begin
    d_n = '0;
    s_n = 1'b0;
    case (cls2)
      CL_ZERO: ;
      CL_NAN:  s_n = 1'b1;
      CL_INF: begin
        d_n = sgn2 ? MIN_V : MAX_V;
        s_n = 1'b1;
      end
      default: begin
        if (ovf2 || (mag2 > (sgn2 ? LIM_NEG : LIM_POS))) begin
          d_n = sgn2 ? MIN_V : MAX_V;
          s_n = 1'b1;
        end else begin
          d_n = sgn2 ? -mag2[O_WIDTH-1:0] : mag2[O_WIDTH-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      odata     <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        odata <= d_n;
        sat   <= s_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Scoreboard bench for fp_to_fixed: directed vectors, reset/bubble behaviour, and a randomized sweep
// checked against a real-arithmetic reference model.
module tb_fp_to_fixed;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] idata;
  logic [15:0] odata;
  logic        out_valid;
  logic        sat;

  fp_to_fixed dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .idata     (idata),
    .odata     (odata),
    .out_valid (out_valid),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        s;
    int          c;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  logic        rst_q = 1'b1;
  logic [15:0] last_d = '0;
  logic        last_s = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference: exact value via real arithmetic, then RNE and saturation
  function automatic void model(input logic [31:0] f, output logic [15:0] d, output logic s);
    int     e;
    real    x, fl, fr, r;
    longint v;
    e = int'(f[30:23]);
    d = '0;
    s = 1'b0;
    if (e == 0) return;
    if (e == 255) begin
      s = 1'b1;
      if (f[22:0] == '0) d = f[31] ? 16'h8000 : 16'h7FFF;
      return;
    end
    x  = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127)) * 4096.0;
    fl = $floor(x);
    fr = x - fl;
    if (fr > 0.5)      r = fl + 1.0;
    else if (fr < 0.5) r = fl;
    else               r = ((longint'(fl) % 2) == 0) ? fl : fl + 1.0;
    if (!f[31] && r > 32767.0) begin
      d = 16'h7FFF;
      s = 1'b1;
    end else if (f[31] && r > 32768.0) begin
      d = 16'h8000;
      s = 1'b1;
    end else begin
      v = longint'(r);
      if (f[31]) v = -v;
      d = v[15:0];
    end
  endfunction

  // anything in flight when reset is sampled is dropped
  always @(posedge clk) begin
    cyc++;
    rst_q = reset;
    if (reset) begin
      q.delete();
      last_d = '0;
      last_s = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_q) begin
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_odata", 32'(odata), 32'd0);
        check_eq("rst_sat", 32'(sat), 32'd0);
      end else if (out_valid) begin
        check_eq("out_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check_eq("odata", 32'(odata), 32'(e.d));
          check_eq("sat", 32'(sat), 32'(e.s));
          check_eq("latency", 32'(cyc - e.c), 32'd3);
          last_d = e.d;
          last_s = e.s;
        end
      end else begin
        check_eq("hold_odata", 32'(odata), 32'(last_d));
        check_eq("hold_sat", 32'(sat), 32'(last_s));
      end
    end
  end

  task automatic step(input logic rst, input logic en, input logic [31:0] f,
                      input logic [15:0] d, input logic s);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = rst;
    enable = en;
    idata  = f;
    if (en && !rst) begin
      e.d = d;
      e.s = s;
      e.c = cyc;
      q.push_back(e);
    end
  endtask

  localparam int NV = 21;
  logic [31:0] vf [NV] = '{
    32'h3FC00000, 32'h3EEEFE8B, 32'hC0000000, 32'h41000000, 32'hC1000000,
    32'h7F800000, 32'hFF800000, 32'h39000000, 32'h39C00000, 32'h3A200000,
    32'h7FC00000, 32'h80000000, 32'h00000001, 32'h00800000, 32'h3FFFFFFF,
    32'hC0FFFFFF, 32'h40FFFFFF, 32'hBF800000, 32'h3B000000, 32'hC6000000,
    32'h39400000};
  logic [15:0] vd [NV] = '{
    16'h1800, 16'h0778, 16'hE000, 16'h7FFF, 16'h8000,
    16'h7FFF, 16'h8000, 16'h0000, 16'h0002, 16'h0002,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2000,
    16'h8000, 16'h7FFF, 16'hF000, 16'h0008, 16'h8000,
    16'h0001};
  logic        vs [NV] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
    1'b0};

  initial begin
    logic [31:0] f;
    logic [15:0] d;
    logic        s;
    int          e;
    int          k;

    reset  = 1'b1;
    enable = 1'b1;
    idata  = 32'h3F800000;
    step(1'b1, 1'b1, 32'h3F800000, 16'h0, 1'b0);

    // back-to-back directed vectors straight out of reset
    for (int i = 0; i < NV; i++)
      step(1'b0, 1'b1, vf[i], vd[i], vs[i]);

    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);

    // item, bubble, reset with enable high, then one surviving item
    step(1'b0, 1'b1, 32'h3F800000, 16'h1000, 1'b0);
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 32'h40000000, 16'h2000, 1'b0);
    step(1'b0, 1'b1, 32'hBF800000, 16'hF000, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) e = int'($urandom_range(0, 255));
      else                           e = int'($urandom_range(105, 142));
      f = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
      model(f, d, s);
      step(1'b0, ($urandom_range(0, 3) != 0), f, d, s);
    end

    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);

    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    check_eq("drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
